// File: rtl/pulse_event_arbiter.sv
// Turns single-cycle event pulses into sticky pending bits and serves their
// indices one at a time, round-robin, over a valid/ready handshake.
module pulse_event_arbiter #(
  parameter int WIDTH = 9,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pulse_in,
  output logic [WIDTH-1:0] pending_out,
  output logic [IDX_W-1:0] m_index,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic             count_clr,
  output logic [CNT_W-1:0] coalesce_count
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int SUM_W = CNT_W + PC_W;

  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + PC_W'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                input logic [PC_W-1:0]  inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(base) + SUM_W'(inc);
    if (sum > SUM_W'({CNT_W{1'b1}})) return '1;
    return sum[CNT_W-1:0];
  endfunction

  logic [WIDTH-1:0] pend_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic [IDX_W-1:0] rr_p1;
  logic [IDX_W-1:0] idx_p2;
  logic             vld_p2;

  logic             ack;
  logic [WIDTH-1:0] ack_mask;
  logic [WIDTH-1:0] cand;
  logic [IDX_W-1:0] rr_base;
  logic             found;
  logic [IDX_W-1:0] sel;

  assign ack      = vld_p2 & m_ready;
  assign ack_mask = ack ? (WIDTH'(1) << idx_p2) : '0;
  assign cand     = pend_p1 & ~ack_mask;
  // On an accept the search already starts after the index just taken.
  assign rr_base  = ack ? ((idx_p2 == IDX_W'(WIDTH - 1)) ? '0 : idx_p2 + IDX_W'(1))
                        : rr_p1;

  always_comb begin
    int pos;
    found = 1'b0;
    sel   = idx_p2;
    pos   = 0;
    for (int k = 0; k < WIDTH; k++) begin
      pos = int'(rr_base) + k;
      if (pos >= WIDTH) pos = pos - WIDTH;
      if (!found && cand[pos]) begin
        found = 1'b1;
        sel   = IDX_W'(pos);
      end
    end
  end

  // Stage 1: sticky pending levels, coalesce counter, round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_p1 <= '0;
      cnt_p1  <= '0;
      rr_p1   <= '0;
    end else begin
      pend_p1 <= cand | pulse_in;
      cnt_p1  <= sat_add(count_clr ? '0 : cnt_p1, popcount(pulse_in & cand));
      if (ack) rr_p1 <= rr_base;
    end
  end

  // Stage 2: presented index; refills only when empty or being accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      idx_p2 <= '0;
    end else if (!vld_p2 || ack) begin
      vld_p2 <= found;
      if (found) idx_p2 <= sel;
    end
  end

  assign pending_out    = pend_p1;
  assign m_index        = idx_p2;
  assign m_valid        = vld_p2;
  assign coalesce_count = cnt_p1;

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Bench for pulse_event_arbiter: a hand-computed vector table run through a
// scoreboard queue, plus a back-to-back drain sequence.
module tb_pulse_event_arbiter;

  logic        clk;
  logic        rst;
  logic [8:0]  pulse_in;
  logic        m_ready;
  logic        count_clr;
  logic [8:0]  pending_out;
  logic [3:0]  m_index;
  logic        m_valid;
  logic [15:0] coalesce_count;
  logic [8:0]  s_pending;
  logic [3:0]  s_index;
  logic        s_valid;
  logic [1:0]  s_count;

  pulse_event_arbiter #(.WIDTH(9), .IDX_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .pending_out(pending_out),
    .m_index(m_index), .m_valid(m_valid), .m_ready(m_ready),
    .count_clr(count_clr), .coalesce_count(coalesce_count)
  );

  pulse_event_arbiter #(.WIDTH(9), .IDX_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .pending_out(s_pending),
    .m_index(s_index), .m_valid(s_valid), .m_ready(m_ready),
    .count_clr(count_clr), .coalesce_count(s_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [8:0]  pulse;
    logic        rdy;
    logic        clr;
    logic [8:0]  pend;
    logic        vld;
    logic [3:0]  idx;
    logic [15:0] cnt;
    logic [1:0]  cnts;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   idx_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic void add(logic r, logic [8:0] p, logic rd, logic cl,
                              logic [8:0] pe, logic v, logic [3:0] ix,
                              logic [15:0] c, logic [1:0] cs);
    vec_t t;
    t.rst = r; t.pulse = p; t.rdy = rd; t.clr = cl;
    t.pend = pe; t.vld = v; t.idx = ix; t.cnt = c; t.cnts = cs;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v, e;
    int delivered, first_c, last_c;
    clk = 0; rst = 1; pulse_in = '0; m_ready = 0; count_clr = 0;

    //  rst pulse  rdy clr | pend  vld idx cnt cnts
    add(1, 9'h000, 0, 0,   9'h000, 0, 0, 0, 0);
    // single event: pending next cycle, presented one later, cleared on accept
    add(0, 9'h004, 1, 0,   9'h004, 0, 0, 0, 0);
    add(0, 9'h000, 1, 0,   9'h004, 1, 2, 0, 0);
    add(0, 9'h000, 1, 0,   9'h000, 0, 2, 0, 0);
    // all lines at once: indices 0..8 back to back
    add(1, 9'h000, 0, 0,   9'h000, 0, 0, 0, 0);
    add(0, 9'h1FF, 1, 0,   9'h1FF, 0, 0, 0, 0);
    add(0, 9'h000, 1, 0,   9'h1FF, 1, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      logic [9:0] sh;
      sh = 10'h1FF << (k + 1);
      add(0, 9'h000, 1, 0, sh[8:0], (k < 8), (k < 8) ? 4'(k + 1) : 4'd8, 0, 0);
    end
    // bits 1,3,7 pending with pointer at 4, stalled for 5 cycles
    add(0, 9'h008, 1, 0,   9'h008, 0, 8, 0, 0);
    add(0, 9'h000, 1, 0,   9'h008, 1, 3, 0, 0);
    add(0, 9'h08A, 1, 0,   9'h08A, 0, 3, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 9'h000, 0, 0, 9'h08A, 1, 7, 0, 0);
    add(0, 9'h000, 1, 0,   9'h00A, 1, 1, 0, 0);
    add(0, 9'h000, 1, 0,   9'h008, 1, 3, 0, 0);
    add(0, 9'h000, 1, 0,   9'h000, 0, 3, 0, 0);
    // coalescing on bit 5, then a pulse colliding with its accept
    add(0, 9'h020, 0, 0,   9'h020, 0, 3, 0, 0);
    add(0, 9'h020, 0, 0,   9'h020, 1, 5, 1, 1);
    add(0, 9'h020, 0, 0,   9'h020, 1, 5, 2, 2);
    add(0, 9'h020, 0, 0,   9'h020, 1, 5, 3, 3);
    add(0, 9'h020, 1, 0,   9'h020, 0, 5, 3, 3);
    add(0, 9'h000, 1, 0,   9'h020, 1, 5, 3, 3);
    add(0, 9'h000, 1, 0,   9'h000, 0, 5, 3, 3);
    // saturation of the 2-bit counter, then clear with a same-cycle event
    add(0, 9'h001, 0, 0,   9'h001, 0, 5, 3, 3);
    add(0, 9'h001, 0, 0,   9'h001, 1, 0, 4, 3);
    add(0, 9'h001, 0, 0,   9'h001, 1, 0, 5, 3);
    add(0, 9'h001, 0, 1,   9'h001, 1, 0, 1, 1);
    add(0, 9'h000, 0, 1,   9'h001, 1, 0, 0, 0);
    // several coalesced bits in one cycle, then reset mid-operation
    add(0, 9'h070, 0, 0,   9'h071, 1, 0, 0, 0);
    add(0, 9'h071, 0, 0,   9'h071, 1, 0, 4, 3);
    add(1, 9'h000, 1, 0,   9'h000, 0, 0, 0, 0);
    add(0, 9'h000, 1, 0,   9'h000, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(negedge clk);
      rst = v.rst; pulse_in = v.pulse; m_ready = v.rdy; count_clr = v.clr;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("row%0d.pending", i), 32'(pending_out), 32'(e.pend));
      chk($sformatf("row%0d.valid", i), 32'(m_valid), 32'(e.vld));
      chk($sformatf("row%0d.index", i), 32'(m_index), 32'(e.idx));
      chk($sformatf("row%0d.count", i), 32'(coalesce_count), 32'(e.cnt));
      chk($sformatf("row%0d.count_sat", i), 32'(s_count), 32'(e.cnts));
    end

    // back-to-back drain: pointer is 0 after the reset above
    @(negedge clk);
    rst = 0; count_clr = 0; pulse_in = 9'h1FF; m_ready = 1;
    for (int i = 0; i < 9; i++) idx_q.push_back(i);
    delivered = 0; first_c = 0; last_c = 0;
    for (int c = 0; c < 40 && delivered < 9; c++) begin
      @(negedge clk);
      pulse_in = '0;
      if (m_valid && m_ready) begin
        if (idx_q.size() > 0) chk("drain.index", 32'(m_index), 32'(idx_q.pop_front()));
        else chk("drain.extra", 32'(m_index), 32'hFFFF_FFFF);
        if (delivered == 0) first_c = c;
        last_c = c;
        delivered++;
      end
    end
    @(negedge clk);
    chk("drain.delivered", 32'(delivered), 32'd9);
    chk("drain.span", 32'(last_c - first_c), 32'd8);
    chk("drain.pending", 32'(pending_out), 32'd0);
    chk("drain.valid", 32'(m_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
